// File: rtl/axi_mem_port_arbiter_pkg.sv
// Shared types for the AXI memory-port arbiter: requester priority and the SRAM request bundle.
package axi_mem_arb_pkg;

    localparam int unsigned DEF_MEM_ADDR_WIDTH = 13;
    localparam int unsigned DEF_DATA_WIDTH     = 64;
    localparam int unsigned DEF_NUMBYTES       = DEF_DATA_WIDTH / 8;

    typedef enum logic {
        PRIO_RD = 1'b0,
        PRIO_WR = 1'b1
    } arb_prio_t;

    typedef struct packed {
        logic                          cen;
        logic                          wen;
        logic [DEF_MEM_ADDR_WIDTH-1:0] a;
        logic [DEF_DATA_WIDTH-1:0]     d;
        logic [DEF_NUMBYTES-1:0]       be;
    } mem_req_t;

endpackage

// File: rtl/axi_mem_port_arbiter_if.sv
// Bundle of the read requester, write requester and SRAM port seen by the arbiter.
interface axi_mem_port_arbiter_if
    import axi_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned NUMBYTES       = DATA_WIDTH / 8
);
    logic                      rd_valid_i;
    logic                      rd_grant_o;
    logic                      rd_cen_i;
    logic                      rd_wen_i;
    logic [MEM_ADDR_WIDTH-1:0] rd_a_i;
    logic [DATA_WIDTH-1:0]     rd_d_i;
    logic [NUMBYTES-1:0]       rd_be_i;
    logic [DATA_WIDTH-1:0]     rd_q_o;
    logic                      rd_rvalid_o;

    logic                      wr_valid_i;
    logic                      wr_grant_o;
    logic                      wr_cen_i;
    logic                      wr_wen_i;
    logic [MEM_ADDR_WIDTH-1:0] wr_a_i;
    logic [DATA_WIDTH-1:0]     wr_d_i;
    logic [NUMBYTES-1:0]       wr_be_i;
    logic [DATA_WIDTH-1:0]     wr_q_o;

    logic                      mem_cen_o;
    logic                      mem_wen_o;
    logic [MEM_ADDR_WIDTH-1:0] mem_a_o;
    logic [DATA_WIDTH-1:0]     mem_d_o;
    logic [NUMBYTES-1:0]       mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_q_i;

    modport slave (
        input  rd_valid_i, rd_cen_i, rd_wen_i, rd_a_i, rd_d_i, rd_be_i,
        input  wr_valid_i, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        input  mem_q_i,
        output rd_grant_o, rd_q_o, rd_rvalid_o, wr_grant_o, wr_q_o,
        output mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o
    );

    modport master (
        output rd_valid_i, rd_cen_i, rd_wen_i, rd_a_i, rd_d_i, rd_be_i,
        output wr_valid_i, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        output mem_q_i,
        input  rd_grant_o, rd_q_o, rd_rvalid_o, wr_grant_o, wr_q_o,
        input  mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o
    );

endinterface

// File: rtl/axi_mem_port_arbiter_mux.sv
// Combinational two-way SRAM request mux; with no selection the port idles on the read-side fields.
module axi_mem_port_mux
    import axi_mem_arb_pkg::*;
(
    input  logic     rd_sel,
    input  logic     wr_sel,
    input  mem_req_t rd_req,
    input  mem_req_t wr_req,
    output mem_req_t mem_req
);

    // Route the winner; idle keeps the address/data lines quiet on the read side.
    always_comb begin
        mem_req = rd_req;
        if (wr_sel) begin
            mem_req = wr_req;
        end else if (rd_sel) begin
            mem_req = rd_req;
        end else begin
            mem_req.cen = 1'b1;
            mem_req.wen = 1'b1;
        end
    end

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between AXI read and write controllers.
// Burst hold window is enabled by defining AXI_MEM_ARB_HOLD_EN; otherwise contested grants strictly alternate.
module axi_mem_port_arbiter
    import axi_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned NUMBYTES       = DATA_WIDTH / 8,
    parameter int unsigned MAX_HOLD       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_mem_port_arbiter_if.slave  bus
);

    // The request bundle type is fixed to the package widths.
    if ((MEM_ADDR_WIDTH != DEF_MEM_ADDR_WIDTH) || (DATA_WIDTH != DEF_DATA_WIDTH) ||
        (NUMBYTES != DEF_NUMBYTES) || (MAX_HOLD < 32'd1)) begin : g_bad_cfg
        $error("axi_mem_port_arbiter: unsupported parameter set");
    end

    mem_req_t  rd_req_s;
    mem_req_t  wr_req_s;
    mem_req_t  mem_req_s;
    arb_prio_t prio_r;
    arb_prio_t prio_nxt_s;
    arb_prio_t win_prio_s;
    arb_prio_t other_prio_s;
    logic      rd_win_s;
    logic      wr_win_s;
    logic      other_valid_s;
    logic      rd_rvalid_r;

`ifdef AXI_MEM_ARB_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
`endif

    assign rd_req_s      = {bus.rd_cen_i, bus.rd_wen_i, bus.rd_a_i, bus.rd_d_i, bus.rd_be_i};
    assign wr_req_s      = {bus.wr_cen_i, bus.wr_wen_i, bus.wr_a_i, bus.wr_d_i, bus.wr_be_i};
    assign win_prio_s    = wr_win_s ? PRIO_WR : PRIO_RD;
    assign other_prio_s  = (prio_r == PRIO_RD) ? PRIO_WR : PRIO_RD;
    assign other_valid_s = rd_win_s ? bus.wr_valid_i : bus.rd_valid_i;

    // State register: priority holder, hold counter and read-data strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r      <= PRIO_RD;
`ifdef AXI_MEM_ARB_HOLD_EN
            hold_cnt_r  <= '0;
`endif
            rd_rvalid_r <= 1'b0;
        end else begin
            prio_r      <= prio_nxt_s;
`ifdef AXI_MEM_ARB_HOLD_EN
            hold_cnt_r  <= hold_cnt_nxt_s;
`endif
            rd_rvalid_r <= rd_win_s & ~bus.rd_cen_i & bus.rd_wen_i;
        end
    end

    // Next-state: hand priority over once the holder has used its contested window.
    always_comb begin
        prio_nxt_s = prio_r;
`ifdef AXI_MEM_ARB_HOLD_EN
        hold_cnt_nxt_s = hold_cnt_r;
`endif
        if (rd_win_s | wr_win_s) begin
            if (win_prio_s != prio_r) begin
                prio_nxt_s = win_prio_s;
`ifdef AXI_MEM_ARB_HOLD_EN
                hold_cnt_nxt_s = '0;
`endif
            end else if (!other_valid_s) begin
                prio_nxt_s = prio_r;
`ifdef AXI_MEM_ARB_HOLD_EN
                hold_cnt_nxt_s = '0;
            end else if (hold_cnt_r == HOLD_W'(MAX_HOLD - 32'd1)) begin
                prio_nxt_s     = other_prio_s;
                hold_cnt_nxt_s = '0;
            end else begin
                hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
            end
`else
            end else begin
                prio_nxt_s = other_prio_s;
            end
`endif
        end else begin
            prio_nxt_s = prio_r;
        end
    end

    // Output decode: the priority holder wins when valid, else the other requester.
    always_comb begin
        rd_win_s = 1'b0;
        wr_win_s = 1'b0;
        case (prio_r)
            PRIO_RD: begin
                if (bus.rd_valid_i) begin
                    rd_win_s = 1'b1;
                end else if (bus.wr_valid_i) begin
                    wr_win_s = 1'b1;
                end else begin
                    rd_win_s = 1'b0;
                end
            end
            PRIO_WR: begin
                if (bus.wr_valid_i) begin
                    wr_win_s = 1'b1;
                end else if (bus.rd_valid_i) begin
                    rd_win_s = 1'b1;
                end else begin
                    wr_win_s = 1'b0;
                end
            end
            default: begin
                rd_win_s = 1'b0;
                wr_win_s = 1'b0;
            end
        endcase
    end

    axi_mem_port_mux u_mux (
        .rd_sel  (rd_win_s),
        .wr_sel  (wr_win_s),
        .rd_req  (rd_req_s),
        .wr_req  (wr_req_s),
        .mem_req (mem_req_s)
    );

    assign bus.rd_grant_o  = rd_win_s;
    assign bus.wr_grant_o  = wr_win_s;
    assign bus.mem_cen_o   = mem_req_s.cen;
    assign bus.mem_wen_o   = mem_req_s.wen;
    assign bus.mem_a_o     = mem_req_s.a;
    assign bus.mem_d_o     = mem_req_s.d;
    assign bus.mem_be_o    = mem_req_s.be;
    assign bus.rd_q_o      = bus.mem_q_i;
    assign bus.wr_q_o      = bus.mem_q_i;
    assign bus.rd_rvalid_o = rd_rvalid_r;

endmodule
